// File: rtl/dff32_en_pkg.sv
// ---------------------------------------------------------------------------
// dff32_en_pkg
//   Shared constants and types for the word-register slice of the single-cycle
//   MIPS datapath (PC register and other plain state holders).
//
//   WORD_WIDTH : datapath word width in bits
//   WORD_ZERO  : all-zero word, used as the clear value of word registers
//   word_t     : convenience type for a full datapath word
// ---------------------------------------------------------------------------
package dff32_en_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

endpackage : dff32_en_pkg

// File: rtl/dff32_en_bit.sv
// ---------------------------------------------------------------------------
// dff1_en
//   Single-bit rising-edge flip-flop with clock enable and asynchronous,
//   active-high clear. Building block for dff32_en.
//
//   Parameters:
//     RESET_BIT : value forced onto q while clrn is high
//
//   Ports:
//     clk  in  1  system clock, rising edge active
//     clrn in  1  asynchronous clear, active-high (1 = clear)
//     d    in  1  data bit to capture
//     e    in  1  clock enable, active-high
//     q    out 1  registered data bit
// ---------------------------------------------------------------------------
module dff1_en #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic clrn,
    input  logic d,
    input  logic e,
    output logic q
);

    logic q_reg;

    // Clear is in the sensitivity list so it acts without a clock edge and
    // dominates any edge that arrives while it is still high.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            q_reg <= RESET_BIT;
        end else if (e) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : dff1_en

// File: rtl/dff32_en.sv
// ---------------------------------------------------------------------------
// dff32_en
//   Word-wide edge-triggered register with clock enable and asynchronous,
//   active-high clear. Used for the PC and other state words of the
//   single-cycle MIPS datapath.
//
//   Parameters:
//     WIDTH       : data width in bits (datapath uses 32)
//     RESET_VALUE : value forced onto q while clrn is high
//
//   Ports:
//     clk  in  1      system clock, rising edge active
//     clrn in  1      asynchronous clear, active-high (the name is historical;
//                     1 means clear)
//     d    in  WIDTH  data word to capture
//     e    in  1      clock enable, active-high
//     q    out WIDTH  registered data word
//
//   Every bit is an independent dff1_en sharing clk, clrn and e; the bit's
//   own slice of RESET_VALUE selects its clear level.
// ---------------------------------------------------------------------------
module dff32_en
    import dff32_en_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(WORD_ZERO)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] d,
    input  logic             e,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff1_en #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_bit (
                .clk  (clk),
                .clrn (clrn),
                .d    (d[gi]),
                .e    (e),
                .q    (q[gi])
            );
        end
    endgenerate

endmodule : dff32_en

// File: tb/tb_dff32_en.sv
// ---------------------------------------------------------------------------
// tb_dff32_en
//   Self-checking bench for dff32_en. A behavioural model holds the word the
//   register must currently show; a compare process checks q against it just
//   after every rising edge and just after every falling edge, and directed
//   phases pin the model with literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dff32_en;

    logic        clk;
    logic        clrn;
    logic [31:0] d;
    logic        e;
    logic [31:0] q;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: the word that must be on q, and whether it is known.
    logic [31:0] model_q     = '0;
    bit          model_known = 1'b0;

    dff32_en #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .d    (d),
        .e    (e),
        .q    (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: q=%08h expected=%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Clearing makes the word known (zero) immediately.
    always @(posedge clrn) begin
        model_q     = 32'h0;
        model_known = 1'b1;
    end

    // At an edge: clear wins, otherwise an enabled edge copies d, else hold.
    always @(posedge clk) begin
        if (clrn === 1'b1) begin
            model_q     = 32'h0;
            model_known = 1'b1;
        end else if (e === 1'b1 && model_known) begin
            model_q = d;
        end else if (e === 1'b1) begin
            model_q     = d;
            model_known = 1'b1;
        end
    end

    // Compare process: after every rising edge and mid-way through the cycle.
    always @(posedge clk) begin
        #1;
        if (model_known) check("model_post_edge", q, model_q);
    end
    always @(negedge clk) begin
        #1;
        if (model_known) check("model_mid_cycle", q, model_q);
    end

    task automatic drive(input logic [31:0] dv, input logic ev, input logic cv);
        @(negedge clk);
        d    = dv;
        e    = ev;
        clrn = cv;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cnt;
        logic [31:0] pat;
        logic [31:0] last_d;

        clrn = 1'b0;
        e    = 1'b0;
        d    = 32'h0;
        #2;
        // Power-up clear without any clock edge.
        clrn = 1'b1;
        #1;
        check("reset_state", q, 32'h0000_0000);

        // Store 0x12, then clear asynchronously mid-cycle.
        drive(32'h0000_0012, 1'b1, 1'b0);
        after_edge();
        check("load_0x12", q, 32'h0000_0012);
        @(posedge clk);
        #5;
        clrn = 1'b1;
        #0.1;
        check("async_clear_mid_cycle", q, 32'h0000_0000);
        // Clear held across 3 enabled edges.
        for (int i = 0; i < 3; i++) begin
            drive(32'hDEAD_BEEF, 1'b1, 1'b1);
            after_edge();
            check("clear_held", q, 32'h0000_0000);
        end

        // Enabled capture of a counting word.
        cnt = 32'h0000_000F;
        for (int i = 0; i < 20; i++) begin
            drive(cnt, 1'b1, 1'b0);
            after_edge();
            check("count_capture", q, 32'h0000_000F + 32'(i));
            cnt = cnt + 32'd1;
        end

        // Enable low holds the stored word.
        drive(32'h1234_5678, 1'b1, 1'b0);
        after_edge();
        for (int i = 0; i < 4; i++) begin
            drive((i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b0, 1'b0);
            after_edge();
            check("enable_low_hold", q, 32'h1234_5678);
        end
        drive(32'hA5A5_A5A5, 1'b1, 1'b0);
        after_edge();
        check("enable_reload", q, 32'hA5A5_A5A5);

        // Clear held over several edges while d counts, then released on a
        // falling edge; the next rising edge captures d.
        cnt = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            drive(cnt, 1'b1, 1'b1);
            after_edge();
            check("clear_while_counting", q, 32'h0000_0000);
            cnt = cnt + 32'd1;
        end
        drive(32'h0000_0777, 1'b1, 1'b0);
        #1;
        check("release_before_edge", q, 32'h0000_0000);
        after_edge();
        check("first_capture_after_release", q, 32'h0000_0777);

        // Walking one across the full width, then all ones.
        pat = 32'h0000_0001;
        for (int i = 0; i < 32; i++) begin
            drive(pat, 1'b1, 1'b0);
            after_edge();
            check("walking_one", q, 32'h1 << i);
            pat = pat << 1;
        end
        drive(32'hFFFF_FFFF, 1'b1, 1'b0);
        after_edge();
        check("all_ones", q, 32'hFFFF_FFFF);

        // Clear dominates enable at an edge.
        drive(32'hFFFF_FFFF, 1'b1, 1'b1);
        after_edge();
        check("clear_beats_enable", q, 32'h0000_0000);

        // Randomised traffic; the compare process checks every half cycle.
        last_d = 32'h0;
        for (int i = 0; i < 300; i++) begin
            drive($urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            last_d = d;
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk);
                #5;
                clrn = 1'b1;
            end
        end
        drive(last_d, 1'b0, 1'b0);
        after_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dff32_en
